// File: rtl/ysyx_220066_memarb.sv
// Two-requester (IF / LS) arbiter that serialises requests onto one valid/ready memory port.
// Handles byte-lane alignment, load extension, misalignment faults and response timeout.
module ysyx_220066_memarb #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [63:0] if_addr,
    output logic        if_ready,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        ls_valid,
    input  logic        ls_wen,
    input  logic [2:0]  ls_op,
    input  logic [63:0] ls_addr,
    input  logic [63:0] ls_wdata,
    output logic        ls_ready,
    output logic        ls_rvalid,
    output logic [63:0] ls_rdata,
    output logic        ls_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [63:0] mem_addr,
    output logic        mem_wen,
    output logic [7:0]  mem_wmask,
    output logic [63:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

    function automatic logic op_fault(input logic [2:0] op, input logic [2:0] a);
        logic f;
        f = 1'b0;
        if (op == 3'b111) begin
            f = 1'b1;
        end else begin
            case (op[1:0])
                2'd1:    f = a[0];
                2'd2:    f = (a[1:0] != 2'b00);
                2'd3:    f = (a != 3'b000);
                default: f = 1'b0;
            endcase
        end
        return f;
    endfunction

    function automatic logic [7:0] byte_mask(input logic [2:0] op, input logic [2:0] a);
        logic [7:0] m;
        case (op[1:0])
            2'd0:    m = 8'h01 << a;
            2'd1:    m = 8'h03 << a;
            2'd2:    m = 8'h0F << a;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    function automatic logic [63:0] load_ext(input logic [2:0] op, input logic [2:0] a,
                                             input logic [63:0] d);
        logic [63:0] sh;
        logic [63:0] r;
        sh = d >> {a, 3'b000};
        case (op)
            3'b000:  r = {{56{sh[7]}}, sh[7:0]};
            3'b001:  r = {{48{sh[15]}}, sh[15:0]};
            3'b010:  r = {{32{sh[31]}}, sh[31:0]};
            3'b011:  r = sh;
            3'b100:  r = {56'd0, sh[7:0]};
            3'b101:  r = {48'd0, sh[15:0]};
            3'b110:  r = {32'd0, sh[31:0]};
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] fetch_lane(input logic a2, input logic [63:0] d);
        return a2 ? d[63:32] : d[31:0];
    endfunction

    state_t      state_q, state_d;
    logic        last_ls_q, last_ls_d;
    logic        own_ls_q, own_ls_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  a_q, a_d;
    logic [2:0]  op_q, op_d;
    logic        wen_q, wen_d;
    logic        mem_valid_q, mem_valid_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic        mem_wen_q, mem_wen_d;
    logic [7:0]  mem_wmask_q, mem_wmask_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        if_err_q, if_err_d;
    logic        ls_rvalid_q, ls_rvalid_d;
    logic [63:0] ls_rdata_q, ls_rdata_d;
    logic        ls_err_q, ls_err_d;

    logic        grant_if, grant_ls;
    logic [63:0] acc_addr;
    logic [2:0]  acc_op;
    logic        acc_wen;
    logic        fire, fire_err;

    // Round-robin: on a tie, the requester that was not served last wins.
    assign grant_if = if_valid && (!ls_valid || last_ls_q);
    assign grant_ls = ls_valid && !grant_if;
    assign if_ready = rst && (state_q == S_IDLE) && grant_if;
    assign ls_ready = rst && (state_q == S_IDLE) && grant_ls;

    // Fetches behave like aligned 32-bit reads for fault checking.
    assign acc_addr = grant_if ? if_addr : ls_addr;
    assign acc_op   = grant_if ? 3'b010 : ls_op;
    assign acc_wen  = grant_ls && ls_wen;

    always_comb begin
        state_d     = state_q;
        last_ls_d   = last_ls_q;
        own_ls_d    = own_ls_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        op_d        = op_q;
        wen_d       = wen_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wen_d   = mem_wen_q;
        mem_wmask_d = mem_wmask_q;
        mem_wdata_d = mem_wdata_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        if_err_d    = if_err_q;
        ls_rvalid_d = 1'b0;
        ls_rdata_d  = ls_rdata_q;
        ls_err_d    = ls_err_q;
        fire        = 1'b0;
        fire_err    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_if || grant_ls) begin
                    own_ls_d = grant_ls;
                    a_d      = acc_addr[2:0];
                    op_d     = acc_op;
                    wen_d    = acc_wen;
                    if (op_fault(acc_op, acc_addr[2:0])) begin
                        fire     = 1'b1;
                        fire_err = 1'b1;
                        state_d  = S_RESP;
                    end else begin
                        state_d     = S_REQ;
                        cnt_d       = 16'd0;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {acc_addr[63:3], 3'b000};
                        mem_wen_d   = acc_wen;
                        mem_wmask_d = acc_wen ? byte_mask(acc_op, acc_addr[2:0]) : 8'h00;
                        mem_wdata_d = acc_wen ? (ls_wdata << {acc_addr[2:0], 3'b000}) : 64'd0;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == TO_CNT) begin
                    mem_valid_d = 1'b0;
                    fire        = 1'b1;
                    fire_err    = 1'b1;
                    state_d     = S_RESP;
                end else if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (mem_rvalid) begin
                    fire    = 1'b1;
                    state_d = S_RESP;
                end else if (cnt_q == TO_CNT) begin
                    fire     = 1'b1;
                    fire_err = 1'b1;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                last_ls_d = own_ls_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Response registers load on entry to RESP so rvalid is high for the RESP cycle only.
        if (fire) begin
            if (own_ls_d) begin
                ls_rvalid_d = 1'b1;
                ls_err_d    = fire_err;
                ls_rdata_d  = (fire_err || wen_d) ? 64'd0 : load_ext(op_d, a_d, mem_rdata);
            end else begin
                if_rvalid_d = 1'b1;
                if_err_d    = fire_err;
                if_rdata_d  = fire_err ? 32'd0 : fetch_lane(a_d[2], mem_rdata);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            last_ls_q   <= 1'b1;
            own_ls_q    <= 1'b0;
            cnt_q       <= 16'd0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 64'd0;
            mem_wen_q   <= 1'b0;
            mem_wmask_q <= 8'h00;
            mem_wdata_q <= 64'd0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= 32'd0;
            if_err_q    <= 1'b0;
            ls_rvalid_q <= 1'b0;
            ls_rdata_q  <= 64'd0;
            ls_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_ls_q   <= last_ls_d;
            own_ls_q    <= own_ls_d;
            cnt_q       <= cnt_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wen_q   <= mem_wen_d;
            mem_wmask_q <= mem_wmask_d;
            mem_wdata_q <= mem_wdata_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            if_err_q    <= if_err_d;
            ls_rvalid_q <= ls_rvalid_d;
            ls_rdata_q  <= ls_rdata_d;
            ls_err_q    <= ls_err_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q   <= a_d;
        op_q  <= op_d;
        wen_q <= wen_d;
    end

    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wen   = mem_wen_q;
    assign mem_wmask = mem_wmask_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign if_err    = if_err_q;
    assign ls_rvalid = ls_rvalid_q;
    assign ls_rdata  = ls_rdata_q;
    assign ls_err    = ls_err_q;

endmodule
